// File: rtl/datamem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter.
package datamem_arb_pkg;
  localparam logic ARB   = 1'b0;
  localparam logic LOCK1 = 1'b1;
  localparam logic M0    = 1'b0;
  localparam logic M1    = 1'b1;
  localparam int   BURST_CNT_W = 8;
endpackage

// File: rtl/datamem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on contention the master not named by 'last' wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/datamem_port_arbiter.sv
// Shares the datamem port A between the LSU (m0) and a secondary master (m1),
// with an m1 burst lock. Wait-cycle counters built only with DATAMEM_ARB_PERF_EN.
module datamem_port_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic              core_clk,
  input  logic              nrst,
  input  logic              m0_req,
  input  logic [3:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [31:0]       perf_m0_wait,
  output logic [31:0]       perf_m1_wait
);
  localparam logic [BURST_CNT_W-1:0] BMAX = BURST_CNT_W'(BURST_MAX);

  logic                   state_q, rr_last_q;
  logic [BURST_CNT_W-1:0] burst_cnt_q, cnt_nxt;
  logic [1:0]             rr_gnt, rvalid_q;
  logic [DATA_W-1:0]      m0_rdata_q, m1_rdata_q;

  rr_arb2 u_rr (.req({m1_req, m0_req}), .last(rr_last_q), .gnt(rr_gnt));

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (nrst) begin
      if (state_q == ARB) {m1_gnt, m0_gnt} = rr_gnt;
      else                m1_gnt = m1_req;
    end
  end

  always_comb begin
    mem_we   = 4'h0;
    mem_addr = m0_addr;
    mem_din  = m0_wdata;
    if (m1_gnt) begin
      mem_we = m1_we; mem_addr = m1_addr; mem_din = m1_wdata;
    end else if (m0_gnt) begin
      mem_we = m0_we;
    end
  end

  // Count includes this cycle's grant, so the BURST_MAX-th beat releases the lock.
  assign cnt_nxt = (m1_gnt && burst_cnt_q < BMAX) ? burst_cnt_q + 1'b1 : burst_cnt_q;

  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      state_q     <= ARB;
      rr_last_q   <= M1;
      burst_cnt_q <= '0;
    end else if (state_q == ARB) begin
      if (m0_req && m1_req) rr_last_q <= m1_gnt ? M1 : M0;
      if (m1_gnt && m1_lock && !(BMAX == 1 && m0_req)) begin
        state_q     <= LOCK1;
        burst_cnt_q <= 1;
      end
    end else begin
      burst_cnt_q <= cnt_nxt;
      if (!m1_lock || (cnt_nxt == BMAX && m0_req)) begin
        state_q     <= ARB;
        rr_last_q   <= M1;
        burst_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      rvalid_q   <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      rvalid_q <= {m1_gnt & ~|m1_we, m0_gnt & ~|m0_we};
      if (rvalid_q[0]) m0_rdata_q <= mem_dout;
      if (rvalid_q[1]) m1_rdata_q <= mem_dout;
    end
  end

  // Reset mid-flight drops the pending response pulse.
  assign m0_rvalid = rvalid_q[0] & nrst;
  assign m1_rvalid = rvalid_q[1] & nrst;
  assign m0_rdata  = m0_rvalid ? mem_dout : m0_rdata_q;
  assign m1_rdata  = m1_rvalid ? mem_dout : m1_rdata_q;

`ifdef DATAMEM_ARB_PERF_EN
  logic [31:0] perf0_q, perf1_q;
  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      perf0_q <= '0;
      perf1_q <= '0;
    end else begin
      if (m0_req && !m0_gnt) perf0_q <= perf0_q + 1'b1;
      if (m1_req && !m1_gnt) perf1_q <= perf1_q + 1'b1;
    end
  end
  assign perf_m0_wait = perf0_q;
  assign perf_m1_wait = perf1_q;
`else
  assign perf_m0_wait = '0;
  assign perf_m1_wait = '0;
`endif
endmodule
